// File: rtl/demux1_4_deser_pkg.sv
// Shared constants for the 1:4 serial deserializer: default slot count,
// slot-counter width derivation and slot index constants.
package demux1_4_deser_pkg;

    localparam int DEF_WIDTH = 4;

    function automatic int sel_w_of(input int w);
        int n;
        n = 0;
        while ((1 << n) < w) n++;
        return n;
    endfunction

    localparam int DEF_SEL_W  = sel_w_of(DEF_WIDTH);
    localparam int SLOT_FIRST = 0;
    localparam int SLOT_LAST  = DEF_WIDTH - 1;

endpackage

// File: rtl/demux_slot_ctr.sv
// Slot counter: clear, load-to-1 on resync, increment with natural wrap
// (WIDTH is a power of two, so wrapping the counter wraps the slot).
module demux_slot_ctr
    import demux1_4_deser_pkg::*;
#(
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic             load1_i,
    output logic [SEL_W-1:0] cnt_o
);

    logic [SEL_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load1_i)    cnt_d = SEL_W'(SLOT_FIRST + 1);
        else if (inc_i) cnt_d = cnt_q + SEL_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) cnt_q <= SEL_W'(SLOT_FIRST);
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/demux1_4_deser.sv
// Serial-to-parallel receiver: steers accepted bits into slots of a word and
// presents each completed word on a valid/ready output handshake.
module demux1_4_deser
    import demux1_4_deser_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    localparam int SEL_W = sel_w_of(WIDTH)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             y_in,
    input  logic             valid_in,
    input  logic             sync_in,
    output logic             ready_out,
    output logic [SEL_W-1:0] sel_out,
    output logic [WIDTH-1:0] a_out,
    output logic             valid_out,
    input  logic             ready_in
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(WIDTH - 1);

    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] sel;
    logic             acc, complete;

    // Only combinational path through the block: ready_in -> ready_out.
    assign ready_out = ~valid_q | ready_in;
    assign acc       = valid_in & ready_out;
    assign complete  = acc & ~sync_in & (sel == LAST);

    demux_slot_ctr #(.SEL_W(SEL_W)) u_ctr (
        .clk_i   (clk_in),
        .clr_i   (rst_in),
        .inc_i   (acc & ~sync_in),
        .load1_i (acc & sync_in),
        .cnt_o   (sel)
    );

    always_comb begin
        shadow_d = shadow_q;
        a_d      = a_q;
        valid_d  = valid_q;
        if (valid_q && ready_in) valid_d = 1'b0;
        if (acc) begin
            if (sync_in) shadow_d[SLOT_FIRST] = y_in;
            else         shadow_d[sel]        = y_in;
        end
        if (complete) begin
            a_d     = {y_in, shadow_q[WIDTH-2:0]};
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            shadow_q <= '0;
            a_q      <= '0;
            valid_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            a_q      <= a_d;
            valid_q  <= valid_d;
        end
    end

    assign sel_out   = sel;
    assign a_out     = a_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_demux1_4_deser.sv
// Scoreboard bench: driver models accepted bits as a list of slot contents,
// a monitor pops expected words whenever the DUT hands one off.
module tb_demux1_4_deser;

    logic       clk_in = 1'b0;
    logic       rst_in, y_in, valid_in, sync_in, ready_in;
    logic       ready_out, valid_out;
    logic [1:0] sel_out;
    logic [3:0] a_out;

    int tests = 0;
    int fails = 0;

    logic [3:0] exp_q[$];
    bit         part[$];
    int         words_out = 0;

    always #5 clk_in = ~clk_in;

    demux1_4_deser dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .y_in     (y_in),
        .valid_in (valid_in),
        .sync_in  (sync_in),
        .ready_out(ready_out),
        .sel_out  (sel_out),
        .a_out    (a_out),
        .valid_out(valid_out),
        .ready_in (ready_in)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive, then at negedge check combinational rules and update model.
    task automatic cyc(input bit r, input bit v, input bit y, input bit s,
                       input bit rdy, output bit acc);
        rst_in = r; valid_in = v; y_in = y; sync_in = s; ready_in = rdy;
        @(negedge clk_in);
        acc = 1'b0;
        if (r) begin
            part.delete();
            exp_q.delete();
        end else begin
            chk("ready_rule", ready_out, int'(!valid_out || rdy));
            chk("sel", sel_out, part.size());
            acc = v && ready_out;
            if (acc) begin
                if (s) part.delete();
                part.push_back(y);
                if (part.size() == 4) begin
                    exp_q.push_back({part[3], part[2], part[1], part[0]});
                    part.delete();
                end
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    // Monitor: pop on handshake; also require holding under backpressure.
    logic       prev_hold = 1'b0;
    logic [3:0] prev_a = '0;
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (prev_hold) begin
                chk("hold_valid", valid_out, 1);
                chk("hold_a", a_out, prev_a);
            end
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) chk("unexpected_word", a_out, -1);
                else chk("word", a_out, exp_q.pop_front());
                words_out++;
            end
        end
        prev_hold = !rst_in && valid_out && !ready_in;
        prev_a    = a_out;
    end

    initial begin
        bit a;
        bit hv, hy, hs;
        cyc(1, 0, 0, 0, 1, a);
        cyc(1, 0, 0, 0, 1, a);
        chk("rst_sel", sel_out, 0);
        chk("rst_a", a_out, 0);
        chk("rst_valid", valid_out, 0);

        // Word 1,0,1,1 -> 4'b1101
        cyc(0, 1, 1, 0, 1, a); cyc(0, 1, 0, 0, 1, a);
        cyc(0, 1, 1, 0, 1, a); cyc(0, 1, 1, 0, 1, a);
        chk("w1_valid", valid_out, 1);
        chk("w1_a", a_out, 4'b1101);
        cyc(0, 0, 0, 0, 1, a);
        chk("w1_valid_fall", valid_out, 0);

        // Back-to-back words
        foreach (part[i]) ;
        cyc(0, 1, 1, 0, 1, a); cyc(0, 1, 0, 0, 1, a);
        cyc(0, 1, 1, 0, 1, a); cyc(0, 1, 0, 0, 1, a);
        chk("b2b_a0", a_out, 4'b0101);
        cyc(0, 1, 0, 0, 1, a); chk("b2b_acc", a, 1);
        cyc(0, 1, 1, 0, 1, a); cyc(0, 1, 1, 0, 1, a); cyc(0, 1, 0, 0, 1, a);
        chk("b2b_a1", a_out, 4'b0110);
        chk("b2b_valid", valid_out, 1);

        // Backpressure: complete with ready_in=0, offer a bit, then release
        cyc(0, 1, 1, 0, 0, a); cyc(0, 1, 1, 0, 0, a);
        cyc(0, 1, 1, 0, 0, a); cyc(0, 1, 0, 0, 0, a);
        chk("bp_valid", valid_out, 1);
        chk("bp_ready", ready_out, 0);
        cyc(0, 1, 1, 0, 0, a); chk("bp_noacc", a, 0);
        chk("bp_sel", sel_out, 0);
        cyc(0, 1, 1, 0, 1, a); chk("bp_acc", a, 1);
        chk("bp_fall", valid_out, 0);
        chk("bp_sel1", sel_out, 1);
        cyc(0, 1, 0, 0, 1, a); cyc(0, 1, 0, 0, 1, a); cyc(0, 1, 0, 0, 1, a);
        chk("bp_a", a_out, 4'b0001);
        cyc(0, 0, 0, 0, 1, a);

        // Resync drops partial word
        cyc(0, 1, 1, 0, 1, a); cyc(0, 1, 1, 0, 1, a);
        cyc(0, 1, 0, 1, 1, a);
        chk("rs_sel", sel_out, 1);
        cyc(0, 1, 0, 0, 1, a); cyc(0, 1, 1, 0, 1, a);
        chk("rs_novalid", valid_out, 0);
        cyc(0, 1, 0, 0, 1, a);
        chk("rs_a", a_out, 4'b0100);
        cyc(0, 0, 0, 0, 1, a);

        // Mid-word reset
        cyc(0, 1, 0, 0, 1, a); cyc(0, 1, 0, 0, 1, a); cyc(0, 1, 0, 0, 1, a);
        cyc(1, 0, 0, 0, 1, a);
        chk("mr_sel", sel_out, 0);
        chk("mr_a", a_out, 0);
        chk("mr_valid", valid_out, 0);
        repeat (4) cyc(0, 1, 1, 0, 1, a);
        chk("mr_a1111", a_out, 4'b1111);
        cyc(0, 0, 0, 0, 1, a);

        // Random traffic; sender holds an offered bit until it is accepted
        hv = 0; hy = 0; hs = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!hv) begin
                hv = ($urandom % 2) != 0;
                hy = ($urandom % 2) != 0;
                hs = ($urandom % 10) == 0;
            end
            cyc(($urandom % 200) == 0, hv, hy, hs, ($urandom % 2) != 0, a);
            if (a || rst_in) hv = 0;
        end
        repeat (3) cyc(0, 0, 0, 0, 1, a);
        chk("drain_empty", exp_q.size(), 0);
        chk("words_seen", int'(words_out > 50), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/demux1_4_deser.md
Name: demux1_4_deser

Overview:
- Receive-side counterpart of the 4:1 mux path: accepts a serial bit stream, one bit per accepted beat, and steers each bit into slot 0..3 of a word.
- Slot select comes from an internal 2-bit counter, not an external input.
- Each completed word is presented downstream on a valid/ready handshake.
- Sits between the serial link and the parallel consumer that originally drove the mux's a_in.

Parameters:
- WIDTH, 4, number of slots per word. Must be a power of two, minimum 2.
- SEL_W, 2, slot counter width. Equals log2(WIDTH); local, not overridable.

Ports:
- clk_in  input  1  clock; all logic on rising edge
- rst_in  input  1  synchronous active-high reset
- y_in  input  1  serial data bit
- valid_in  input  1  y_in is valid this cycle
- sync_in  input  1  frame start; qualified by valid_in; marks this bit as slot 0
- ready_out  output  1  block can accept a bit this cycle
- sel_out  output  SEL_W  slot the next accepted bit will occupy
- a_out  output  WIDTH  assembled word; a_out[k] = bit received in slot k
- valid_out  output  1  a_out holds a complete word
- ready_in  input  1  downstream accepts a_out this cycle

Behaviour:
- Reset (rst_in=1 at a clock edge) forces:
  - sel_out=0, shadow register=0, a_out=0, valid_out=0.
  - Any partial word or pending output is discarded.
  - rst_in has priority over every other input.
- Accept condition: acc = valid_in & ready_out.
- Backpressure: ready_out = ~valid_out | ready_in. This is combinational from ready_in, so a pop and the completion of the next word may occur in the same cycle without a bubble.
- Pop: when valid_out & ready_in, valid_out clears next cycle unless a new word completes that same cycle.
- Normal accept with sync_in=0:
  - shadow[sel_out] <= y_in.
  - If sel_out != WIDTH-1: sel_out <= sel_out+1.
  - If sel_out == WIDTH-1 (word completes):
    - a_out <= {y_in, shadow[WIDTH-2:0]}
    - valid_out <= 1
    - sel_out <= 0 (wrap)
    - Latency: the final bit is visible on a_out one cycle after its accept edge.
- Resync (acc & sync_in):
  - Partial word is dropped; no word is output for it.
  - y_in is written to shadow[0] and sel_out <= 1.
  - WIDTH-1 further bits complete the word.
  - sync_in when sel_out=0 is benign; behaviour is identical to a normal accept.
- valid_in=1 while ready_out=0: bit is not accepted and no state changes. The sender must hold y_in and sync_in until accepted.
- a_out and valid_out are stable while valid_out=1 and ready_in=0.
- shadow bits of unfilled slots are not cleared between words. Only completed words reach a_out, so this is invisible externally.
- No combinational path from y_in or valid_in to any output. The only combinational path is ready_in -> ready_out.
- Mid-word reset: sel_out returns to 0, and the first bit after reset is slot 0 regardless of sync_in.

Decomposition:
- Shared package holds:
  - WIDTH default and SEL_W derivation (clog2 constant function).
  - Slot index constants SLOT_FIRST=0 and SLOT_LAST=WIDTH-1.
- One natural sub-module, demux_slot_ctr: SEL_W-bit counter with inc, load-to-1 (resync) and synchronous clear. The top level holds the shadow register, output register and handshake logic.

Test Plan:
- Reset then 4 bits 1,0,1,1 with valid_in=1, ready_in=1 → valid_out=1 for one cycle with a_out=4'b1101; sel_out sequence 0,1,2,3,0.
- Back-to-back words 1010 then 0110 (bits LSB first, continuous valid_in, ready_in=1) → a_out=4'b0101 then 4'b0110; valid_out high in both completing cycles; ready_out never drops.
- Complete a word with ready_in=0 → valid_out and a_out held, ready_out=0. Offer a bit with valid_in=1 → sel_out unchanged. Raise ready_in → bit accepted in that same cycle and valid_out falls next cycle.
- Send 2 bits 1,1, then sync_in=1 with bit 0, then bits 0,1,0 → single word a_out=4'b0100, sel_out goes 0,1,2,1,2,3,0, no output for the dropped partial word.
- Assert rst_in after 3 bits → all outputs 0 next cycle. Then send 1,1,1,1 → a_out=4'b1111, confirming the partial word was discarded.
- Randomised bits with valid_in and ready_in each 50% duty over 1000 cycles → scoreboard: every output word equals the corresponding 4 accepted bits; no word lost or duplicated.
